// File: rtl/bin2bcd_converter_pkg.sv
// Shared widths, defaults and FSM state encoding for the binary-to-BCD converter.
package bin2bcd_converter_pkg;

  localparam int unsigned DEF_BIN_W  = 21;
  localparam int unsigned DEF_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_converter_digit_adj.sv
// One BCD digit pre-adjust for double-dabble: add 3 when the digit is 5 or more.
module bin2bcd_converter_digit_adj
  import bin2bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Input is always <= 9, so the 4-bit sum never carries out.
  assign dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bin2bcd_converter.sv
// Iterative binary-to-BCD converter: one bit per clock, with saturation above 10^DIGITS-1.
module bin2bcd_converter
  import bin2bcd_converter_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    ready,
  output logic                    done_tick,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] BCD_MAX = BIN_W'(10 ** DIGITS - 1);
  localparam logic [BCD_W-1:0] BCD_SAT = {DIGITS{4'h9}};

  state_e             state;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_nxt;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bin2bcd_converter_digit_adj u_adj (
      .din  (work_q[DIGIT_W*d +: DIGIT_W]),
      .dout (work_adj[DIGIT_W*d +: DIGIT_W])
    );
  end

  // Shift the adjusted digits left, pulling in the next binary MSB.
  assign work_nxt = BCD_W'({work_adj, shift_q[BIN_W-1]});
  assign ready    = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (bin > BCD_MAX) begin
              bcd       <= BCD_SAT;
              ovf       <= 1'b1;
              done_tick <= 1'b1;
              state     <= ST_DONE;
            end else begin
              shift_q <= bin;
              work_q  <= '0;
              ovf     <= 1'b0;
              cnt_q   <= CNT_W'(BIN_W);
              state   <= ST_OP;
            end
          end
        end
        ST_OP: begin
          work_q  <= work_nxt;
          shift_q <= {shift_q[BIN_W-2:0], 1'b0};
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            bcd       <= work_nxt;
            done_tick <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: directed vectors, corner sequences, random sweep.
module tb_bin2bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [20:0] bin;
  logic        ready;
  logic        done_tick;
  logic [23:0] bcd;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  bin2bcd_converter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] bin;
    logic [23:0] bcd;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Decimal digits by plain arithmetic; saturate above 999999.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    if (v > 999999) return 24'h999999;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Wait for ready, launch one conversion, report result and done_tick latency in clocks.
  task automatic do_conv(input logic [20:0] b, output logic [23:0] rb, output logic ro,
                         output int lat);
    int g;
    lat = -1;
    rb  = '0;
    ro  = 1'b0;
    @(negedge clk);
    g = 0;
    while (!ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    bin   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_tick) begin
        lat = k;
        rb  = bcd;
        ro  = ovf;
        break;
      end
    end
  endtask

  vec_t        vecs[10];
  logic [23:0] rb;
  logic        ro;
  int          lat;
  int          ticks;
  int          tick_at[2];
  logic [23:0] tick_bcd[2];
  int unsigned rv;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;

    vecs[0] = '{21'd0,       24'h000000, 1'b0, 22};
    vecs[1] = '{21'd832040,  24'h832040, 1'b0, 22};
    vecs[2] = '{21'd1,       24'h000001, 1'b0, 22};
    vecs[3] = '{21'd10,      24'h000010, 1'b0, 22};
    vecs[4] = '{21'd999999,  24'h999999, 1'b0, 22};
    vecs[5] = '{21'd1000000, 24'h999999, 1'b1, 1};
    vecs[6] = '{21'd2097151, 24'h999999, 1'b1, 1};
    vecs[7] = '{21'd99,      24'h000099, 1'b0, 22};
    vecs[8] = '{21'd100000,  24'h100000, 1'b0, 22};
    vecs[9] = '{21'd55555,   24'h055555, 1'b0, 22};

    #3;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done",  32'(done_tick), 32'd0);
    check("reset_bcd",   32'(bcd), 32'd0);
    check("reset_ovf",   32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_conv(vecs[i].bin, rb, ro, lat);
      check($sformatf("vec%0d_bcd", i), 32'(rb), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Restart attempts while busy are ignored; result is from the first bin.
    @(negedge clk);
    bin   = 21'd123456;
    start = 1'b1;
    ticks = 0;
    tick_bcd[0] = '0;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_tick) begin
        ticks++;
        tick_bcd[0] = bcd;
      end
      start = (k < 22);
      bin   = 21'($urandom_range(0, 999999));
    end
    check("busy_ticks", 32'(ticks), 32'd1);
    check("busy_bcd",   32'(tick_bcd[0]), 32'h123456);

    // Asynchronous reset mid-conversion aborts without a done_tick.
    @(negedge clk);
    bin   = 21'd777777;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_bcd",   32'(bcd), 32'd0);
    check("arst_ovf",   32'(ovf), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ticks = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_tick) ticks++;
    end
    check("arst_no_done", 32'(ticks), 32'd0);
    do_conv(21'd654321, rb, ro, lat);
    check("post_rst_bcd", 32'(rb), 32'h654321);
    check("post_rst_lat", 32'(lat), 32'd22);

    // start held across done_tick: second conversion accepted in the following IDLE cycle.
    @(negedge clk);
    bin   = 21'd314159;
    start = 1'b1;
    ticks = 0;
    tick_at[0] = -1;
    tick_at[1] = -1;
    tick_bcd[0] = '0;
    tick_bcd[1] = '0;
    @(posedge clk);
    #1 bin = 21'd271828;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_tick) begin
        if (ticks < 2) begin
          tick_at[ticks]  = k;
          tick_bcd[ticks] = bcd;
        end
        ticks++;
        if (ticks == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_ticks", 32'(ticks), 32'd2);
    check("b2b_at0",   32'(tick_at[0]), 32'd22);
    check("b2b_bcd0",  32'(tick_bcd[0]), 32'h314159);
    check("b2b_at1",   32'(tick_at[1]), 32'd45);
    check("b2b_bcd1",  32'(tick_bcd[1]), 32'h271828);

    // Random sweep against the arithmetic model, including the saturation range.
    for (int i = 0; i < 40; i++) begin
      rv = (i % 4 == 3) ? $urandom_range(0, 2097151) : $urandom_range(0, 999999);
      do_conv(21'(rv), rb, ro, lat);
      check($sformatf("rnd%0d_bcd(%0d)", i, rv), 32'(rb), 32'(ref_bcd(rv)));
      check($sformatf("rnd%0d_ovf(%0d)", i, rv), 32'(ro), 32'(rv > 999999));
      check($sformatf("rnd%0d_lat(%0d)", i, rv), 32'(lat), (rv > 999999) ? 32'd1 : 32'd22);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
